// File: rtl/eq_pkg.sv
// Shared constants, FSM state encoding and saturation helpers for the equalizer mix core.
// Helpers take a sign-extended 64-bit value, so they serve any input width up to 64 bits.
package eq_pkg;

  localparam int EQ_NUM_CH    = 2;
  localparam int EQ_NUM_BANDS = 5;
  localparam int EQ_DATA_W    = 16;
  localparam int EQ_POT_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_VOL  = 2'd2,
    ST_DONE = 2'd3
  } eq_state_e;

  function automatic longint sat_val(input longint x, input int out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  function automatic logic sat_clip(input longint x, input int out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/eq_mix_core_if.sv
// Bus bundle between the band filter bank / codec side and eq_mix_core.
// smpl_vld is a level; each 0->1 transition requests one frame. There is no ready:
// a request arriving while the core is busy is dropped and flagged on ovr.
// out_smpl is only meaningful in the cycle out_vld pulses.
interface eq_mix_core_if
  import eq_pkg::*;
#(
  parameter int NUM_CH    = EQ_NUM_CH,
  parameter int NUM_BANDS = EQ_NUM_BANDS,
  parameter int DATA_W    = EQ_DATA_W,
  parameter int POT_W     = EQ_POT_W
);

  logic                                 smpl_vld;
  logic [NUM_CH*NUM_BANDS*DATA_W-1:0]   band_smpl;
  logic [NUM_BANDS*POT_W-1:0]           band_pot;
  logic [POT_W-1:0]                     vol_pot;
  logic                                 mute;
  logic [NUM_CH*DATA_W-1:0]             out_smpl;
  logic                                 out_vld;
  logic                                 busy;
  logic                                 ovr;

  modport master (
    output smpl_vld, band_smpl, band_pot, vol_pot, mute,
    input  out_smpl, out_vld, busy, ovr
  );

  modport slave (
    input  smpl_vld, band_smpl, band_pot, vol_pot, mute,
    output out_smpl, out_vld, busy, ovr
  );

endinterface

// File: rtl/eq_gain_mul.sv
// Shared gain multiplier: signed sample times unsigned pot, floor-shifted so that
// pot = 2^(POT_W-1) is unity gain. The result always fits DATA_W+1 signed bits.
module eq_gain_mul #(
  parameter int DATA_W = 16,
  parameter int POT_W  = 12
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic        [POT_W-1:0]  b_i,
  output logic signed [DATA_W:0]   p_o
);

  logic signed [POT_W:0]        b_s;
  logic signed [DATA_W+POT_W:0] prod;
  logic                         unused_lsbs;

  assign b_s  = {1'b0, b_i};
  assign prod = a_i * b_s;
  // Taking bits above the binary point of a two's complement product is a floor shift.
  assign p_o  = prod[POT_W-1 +: DATA_W+1];
  assign unused_lsbs = ^{prod[POT_W-2:0], prod[DATA_W+POT_W]};

endmodule

// File: rtl/eq_mix_core.sv
// Band-gain, sum and volume engine: one shared multiplier sequenced per channel/band.
// Optional feature macro SAT_CNT_EN adds a saturating clip-event counter port sat_cnt.
module eq_mix_core
  import eq_pkg::*;
#(
  parameter int NUM_CH    = EQ_NUM_CH,
  parameter int NUM_BANDS = EQ_NUM_BANDS,
  parameter int DATA_W    = EQ_DATA_W,
  parameter int POT_W     = EQ_POT_W
) (
  input  logic           clk,
  input  logic           rst,
  eq_mix_core_if.slave   bus,
  output eq_state_e      dbg_state_o
`ifdef SAT_CNT_EN
  ,
  output logic [15:0]    sat_cnt
`endif
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int AW     = DATA_W + 1 + $clog2(NUM_BANDS);

  eq_state_e                            state_q, state_d;
  logic                                 vld_q;
  logic [CH_W-1:0]                      ch_q;
  logic [BAND_W-1:0]                    band_q;
  logic signed [AW-1:0]                 acc_q;
  logic [NUM_CH*NUM_BANDS*DATA_W-1:0]   smpl_q;
  logic [NUM_BANDS*POT_W-1:0]           pot_q;
  logic [POT_W-1:0]                     vol_q;
  logic                                 mute_q;
  logic [NUM_CH*DATA_W-1:0]             out_q;
  logic                                 ovr_q;

  logic                                 start;
  logic                                 last_band, last_ch;
  int                                   sel_idx;
  logic signed [DATA_W-1:0]             sat_acc, vol_res, mul_a;
  logic        [POT_W-1:0]              mul_b;
  logic signed [DATA_W:0]               mul_p;
  logic                                 clip_acc, clip_vol;

  assign start     = bus.smpl_vld & ~vld_q;
  assign last_band = (band_q == BAND_W'(NUM_BANDS - 1));
  assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_MAC;
      ST_MAC:  if (last_band) state_d = ST_VOL;
      ST_VOL:  state_d = last_ch ? ST_DONE : ST_MAC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.out_vld = (state_q == ST_DONE);
    dbg_state_o = state_q;
  end

  assign bus.out_smpl = out_q;
  assign bus.ovr      = ovr_q;

  // Operand mux: band sample/pot during MAC, saturated sum/volume otherwise.
  always_comb begin
    sel_idx  = int'(ch_q) * NUM_BANDS + int'(band_q);
    sat_acc  = DATA_W'(sat_val(longint'(acc_q), DATA_W));
    clip_acc = sat_clip(longint'(acc_q), DATA_W);
    mul_a    = sat_acc;
    mul_b    = vol_q;
    if (state_q == ST_MAC) begin
      mul_a = smpl_q[sel_idx*DATA_W +: DATA_W];
      mul_b = pot_q[int'(band_q)*POT_W +: POT_W];
    end
    vol_res  = DATA_W'(sat_val(longint'(mul_p), DATA_W));
    clip_vol = sat_clip(longint'(mul_p), DATA_W);
  end

  eq_gain_mul #(.DATA_W(DATA_W), .POT_W(POT_W)) u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      band_q  <= '0;
      acc_q   <= '0;
      smpl_q  <= '0;
      pot_q   <= '0;
      vol_q   <= '0;
      mute_q  <= 1'b0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= bus.smpl_vld;
      if (start && state_q != ST_IDLE) ovr_q <= 1'b1;
      case (state_q)
        ST_IDLE: if (start) begin
          smpl_q <= bus.band_smpl;
          pot_q  <= bus.band_pot;
          vol_q  <= bus.vol_pot;
          mute_q <= bus.mute;
          ch_q   <= '0;
          band_q <= '0;
          acc_q  <= '0;
        end
        ST_MAC: begin
          acc_q  <= acc_q + AW'(mul_p);
          band_q <= last_band ? '0 : band_q + BAND_W'(1);
        end
        ST_VOL: begin
          out_q[int'(ch_q)*DATA_W +: DATA_W] <= mute_q ? '0 : vol_res;
          acc_q <= '0;
          if (!last_ch) ch_q <= ch_q + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (state_q == ST_VOL && (clip_acc || clip_vol) && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = clip_acc ^ clip_vol;
`endif

endmodule

// File: tb/tb_eq_mix_core.sv
// Directed bench for eq_mix_core: timing, gain/sum, saturation, volume/mute, overrun, reset abort.
// Build with SAT_CNT_EN defined to also check the clip counter.
module tb_eq_mix_core;
  import eq_pkg::*;

  localparam int NC = 2;
  localparam int NB = 5;
  localparam int DW = 16;
  localparam int PW = 12;

  logic      clk;
  logic      rst;
  eq_state_e dbg;
`ifdef SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat, nvld, nbusy;
  logic busy_first;

  eq_mix_core_if #(.NUM_CH(NC), .NUM_BANDS(NB), .DATA_W(DW), .POT_W(PW)) bus ();

  eq_mix_core #(.NUM_CH(NC), .NUM_BANDS(NB), .DATA_W(DW), .POT_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg)
`ifdef SAT_CNT_EN
    ,
    .sat_cnt     (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] lane(input int c);
    return bus.out_smpl[c*DW +: DW];
  endfunction

  task automatic clear_in();
    bus.band_smpl = '0;
    for (int b = 0; b < NB; b++) bus.band_pot[b*PW +: PW] = 12'd2048;
    bus.vol_pot = 12'd2048;
    bus.mute    = 1'b0;
  endtask

  task automatic put(input int c, input int b, input logic [15:0] v);
    bus.band_smpl[(c*NB+b)*DW +: DW] = v;
  endtask

  // Raise smpl_vld, then watch 40 cycles recording out_vld latency/count and busy count.
  task automatic do_frame();
    @(negedge clk);
    bus.smpl_vld = 1'b1;
    @(posedge clk);
    lat = 0; nvld = 0; nbusy = 0; busy_first = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.smpl_vld = 1'b0;
        busy_first = bus.busy;
      end
      if (bus.busy) nbusy++;
      if (bus.out_vld) begin
        nvld++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.smpl_vld = 1'b0;
    clear_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_out_vld", 32'(bus.out_vld), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_ovr", 32'(bus.ovr), 32'(0));
    chk("rst_out", 32'(bus.out_smpl), 32'(0));
    chk("rst_state", 32'(dbg), 32'(ST_IDLE));
`ifdef SAT_CNT_EN
    chk("rst_sat_cnt", 32'(sat_cnt), 32'(0));
`endif

    // Timing
    do_frame();
    chk("tim_latency", 32'(lat), 32'(13));
    chk("tim_nvld", 32'(nvld), 32'(1));
    chk("tim_nbusy", 32'(nbusy), 32'(13));
    chk("tim_busy_first", 32'(busy_first), 32'(1));

    // Single band, unity pots
    clear_in();
    put(0, 2, 16'd1000);
    put(1, 4, 16'hFFFF);
    do_frame();
    chk("unity_ch0", 32'(lane(0)), 32'(16'd1000));
    chk("unity_ch1", 32'(lane(1)), 32'(16'hFFFF));

    // Positive saturation of the band sum
    clear_in();
    for (int b = 0; b < NB; b++) begin
      put(0, b, 16'h7000);
      bus.band_pot[b*PW +: PW] = 12'd4095;
    end
    do_frame();
    chk("satp_ch0", 32'(lane(0)), 32'(16'h7FFF));
    chk("satp_ch1", 32'(lane(1)), 32'(16'h0000));
`ifdef SAT_CNT_EN
    chk("satp_cnt", 32'(sat_cnt), 32'(1));
`endif

    // Negative saturation of the band sum
    for (int b = 0; b < NB; b++) put(0, b, 16'h9000);
    do_frame();
    chk("satn_ch0", 32'(lane(0)), 32'(16'h8000));
`ifdef SAT_CNT_EN
    chk("satn_cnt", 32'(sat_cnt), 32'(2));
`endif

    // Volume and mute
    clear_in();
    put(0, 0, 16'd8000);
    bus.vol_pot = 12'd1024;
    do_frame();
    chk("vol_half", 32'(lane(0)), 32'(16'd4000));
    bus.vol_pot = 12'd0;
    do_frame();
    chk("vol_zero", 32'(lane(0)), 32'(16'd0));
    bus.vol_pot = 12'd2048;
    bus.mute = 1'b1;
    do_frame();
    chk("mute_ch0", 32'(lane(0)), 32'(16'd0));
    chk("mute_nvld", 32'(nvld), 32'(1));

    // Half band pot with floor on a negative sample
    clear_in();
    bus.band_pot[0 +: PW] = 12'd1024;
    put(0, 0, 16'd8000);
    put(1, 0, 16'hFFFD);
    do_frame();
    chk("half_ch0", 32'(lane(0)), 32'(16'd4000));
    chk("floor_ch1", 32'(lane(1)), 32'(16'hFFFE));

    // Volume-stage clip on ch0, near-2x gain on ch1
    clear_in();
    bus.band_pot[1*PW +: PW] = 12'd4095;
    put(0, 0, 16'd20000);
    put(1, 1, 16'd1000);
    bus.vol_pot = 12'd4095;
    do_frame();
    chk("volclip_ch0", 32'(lane(0)), 32'(16'h7FFF));
    chk("maxpot_ch1", 32'(lane(1)), 32'(16'd3997));
`ifdef SAT_CNT_EN
    chk("volclip_cnt", 32'(sat_cnt), 32'(3));
`endif

    // Overrun: second rising edge 5 cycles into the frame with different inputs
    clear_in();
    put(0, 0, 16'd1000);
    @(negedge clk);
    bus.smpl_vld = 1'b1;
    @(posedge clk);
    lat = 0; nvld = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) bus.smpl_vld = 1'b0;
      if (i == 5) begin
        bus.smpl_vld = 1'b1;
        put(0, 0, 16'd2222);
      end
      if (i == 6) bus.smpl_vld = 1'b0;
      if (bus.out_vld) begin
        nvld++;
        if (lat == 0) lat = i;
      end
    end
    chk("ovr_flag", 32'(bus.ovr), 32'(1));
    chk("ovr_nvld", 32'(nvld), 32'(1));
    chk("ovr_latency", 32'(lat), 32'(13));
    chk("ovr_ch0", 32'(lane(0)), 32'(16'd1000));
    do_frame();
    chk("ovr_next_ch0", 32'(lane(0)), 32'(16'd2222));
    chk("ovr_sticky", 32'(bus.ovr), 32'(1));

    // Reset mid-frame
    clear_in();
    put(0, 1, 16'd777);
    @(negedge clk);
    bus.smpl_vld = 1'b1;
    @(posedge clk);
    nvld = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.smpl_vld = 1'b0;
      if (i == 6) rst = 1'b1;
      if (i == 7) rst = 1'b0;
      if (bus.out_vld) nvld++;
    end
    chk("abort_nvld", 32'(nvld), 32'(0));
    chk("abort_out", 32'(bus.out_smpl), 32'(0));
    chk("abort_ovr", 32'(bus.ovr), 32'(0));
    chk("abort_busy", 32'(bus.busy), 32'(0));
`ifdef SAT_CNT_EN
    chk("abort_sat_cnt", 32'(sat_cnt), 32'(0));
`endif
    clear_in();
    put(0, 3, 16'hFE0C);
    do_frame();
    chk("post_rst_latency", 32'(lat), 32'(13));
    chk("post_rst_ch0", 32'(lane(0)), 32'(16'hFE0C));
    chk("post_rst_ch1", 32'(lane(1)), 32'(16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
